// File: rtl/axi_sram_responder.sv
// AXI4-subset responder backed by a single-clock SRAM with one write and one read port.
// The write (AW/W/B) and read (AR/R) engines are independent; each accepts one burst at a time.
module axi_sram_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDRS      = 27,
    parameter int REQID      = 4,
    parameter int DEPTH_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 axi_awvalid_i,
    output logic                 axi_awready_o,
    input  logic [ADDRS-1:0]     axi_awaddr_i,
    input  logic [REQID-1:0]     axi_awid_i,
    input  logic [7:0]           axi_awlen_i,
    input  logic [1:0]           axi_awburst_i,
    input  logic                 axi_wvalid_i,
    output logic                 axi_wready_o,
    input  logic                 axi_wlast_i,
    input  logic [WIDTH/8-1:0]   axi_wstrb_i,
    input  logic [WIDTH-1:0]     axi_wdata_i,
    output logic                 axi_bvalid_o,
    input  logic                 axi_bready_i,
    output logic [1:0]           axi_bresp_o,
    output logic [REQID-1:0]     axi_bid_o,
    input  logic                 axi_arvalid_i,
    output logic                 axi_arready_o,
    input  logic [ADDRS-1:0]     axi_araddr_i,
    input  logic [REQID-1:0]     axi_arid_i,
    input  logic [7:0]           axi_arlen_i,
    input  logic [1:0]           axi_arburst_i,
    output logic                 axi_rvalid_o,
    input  logic                 axi_rready_i,
    output logic                 axi_rlast_o,
    output logic [1:0]           axi_rresp_o,
    output logic [REQID-1:0]     axi_rid_o,
    output logic [WIDTH-1:0]     axi_rdata_o
);
    localparam int BYTES = WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int DEPTH = 1 << DEPTH_BITS;

    typedef logic [DEPTH_BITS-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // FIXED holds the index; INCR, WRAP and reserved all advance it.
    function automatic idx_t next_idx(input idx_t i, input logic [1:0] burst);
        return (burst == 2'b00) ? i : idx_t'(i + idx_t'(1));
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sram_q;

    // Upper and sub-word address bits are intentionally ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{axi_awaddr_i, axi_araddr_i};

    w_state_t         w_state_q, w_state_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [REQID-1:0] bid_q, bid_d;
    idx_t             widx_q, widx_d;
    logic [7:0]       wlen_q, wlen_d;
    logic [1:0]       wburst_q, wburst_d;
    logic             werr_q, werr_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             wover_q, wover_d;
    logic             mem_we;

    assign mem_we = (w_state_q == W_DATA) && axi_wvalid_i && wready_q;

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        wcnt_d    = wcnt_q;
        wover_d   = wover_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid_i && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    widx_d    = axi_awaddr_i[OFF+DEPTH_BITS-1:OFF];
                    wlen_d    = axi_awlen_i;
                    wburst_d  = axi_awburst_i;
                    werr_d    = axi_awburst_i[1];
                    wcnt_d    = 8'd0;
                    wover_d   = 1'b0;
                    bid_d     = axi_awid_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (mem_we) begin
                    widx_d = next_idx(widx_q, wburst_q);
                    wcnt_d = 8'(wcnt_q + 8'd1);
                    if (axi_wlast_i) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (wcnt_q == wlen_q && !wover_q && !werr_q) ? 2'b00 : 2'b10;
                        w_state_d = W_RESP;
                    end else if (wcnt_q == wlen_q) begin
                        // Sticky so a wrapped beat counter cannot later look like a match.
                        wover_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready_i) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= 8'd0;
            wburst_q  <= 2'b00;
            werr_q    <= 1'b0;
            wcnt_q    <= 8'd0;
            wover_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            wcnt_q    <= wcnt_d;
            wover_q   <= wover_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi_wstrb_i[b]) mem[widx_q][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    r_state_t         r_state_q, r_state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q, rlast_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [REQID-1:0] rid_q, rid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    idx_t             ridx_q, ridx_d;
    logic [7:0]       rlen_q, rlen_d;
    logic [1:0]       rburst_q, rburst_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             rd_en;
    idx_t             rd_addr;

    // sram_q only reloads when its word is consumed, so it doubles as the stall skid.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rd_en     = 1'b0;
        rd_addr   = ridx_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid_i && arready_q) begin
                    arready_d = 1'b0;
                    rd_en     = 1'b1;
                    rd_addr   = axi_araddr_i[OFF+DEPTH_BITS-1:OFF];
                    ridx_d    = next_idx(axi_araddr_i[OFF+DEPTH_BITS-1:OFF], axi_arburst_i);
                    rlen_d    = axi_arlen_i;
                    rburst_d  = axi_arburst_i;
                    rresp_d   = axi_arburst_i[1] ? 2'b10 : 2'b00;
                    rid_d     = axi_arid_i;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rvalid_d  = 1'b1;
                rdata_d   = sram_q;
                rlast_d   = (rlen_q == 8'd0);
                rcnt_d    = 8'd0;
                rd_en     = 1'b1;
                ridx_d    = next_idx(ridx_q, rburst_q);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && axi_rready_i) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d = sram_q;
                        rcnt_d  = 8'(rcnt_q + 8'd1);
                        rlast_d = (8'(rcnt_q + 8'd1) == rlen_q);
                        rd_en   = 1'b1;
                        ridx_d  = next_idx(ridx_q, rburst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= 8'd0;
            rburst_q  <= 2'b00;
            rcnt_q    <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Nonblocking update gives read-before-write against the write port.
    always_ff @(posedge clock) begin
        if (rd_en) sram_q <= mem[rd_addr];
    end

    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_bid_o     = bid_q;
    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rlast_o   = rlast_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rid_o     = rid_q;
    assign axi_rdata_o   = rdata_q;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: directed and random bursts checked against a word-array memory model.
module tb_axi_sram_responder;
    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        axi_awvalid_i = 1'b0;
    logic        axi_awready_o;
    logic [26:0] axi_awaddr_i = '0;
    logic [3:0]  axi_awid_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [1:0]  axi_awburst_i = '0;
    logic        axi_wvalid_i = 1'b0;
    logic        axi_wready_o;
    logic        axi_wlast_i = 1'b0;
    logic [3:0]  axi_wstrb_i = '0;
    logic [31:0] axi_wdata_i = '0;
    logic        axi_bvalid_o;
    logic        axi_bready_i = 1'b0;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [26:0] axi_araddr_i = '0;
    logic [3:0]  axi_arid_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [1:0]  axi_arburst_i = '0;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;
    logic        axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;

    always #5 clock = ~clock;

    axi_sram_responder #(.WIDTH(32), .ADDRS(27), .REQID(4), .DEPTH_BITS(10)) dut (
        .clock(clock), .reset(reset),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wlast_i(axi_wlast_i),
        .axi_wstrb_i(axi_wstrb_i), .axi_wdata_i(axi_wdata_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o),
        .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
        .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rlast_o(axi_rlast_o),
        .axi_rresp_o(axi_rresp_o), .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int word_of(input logic [26:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic int beat_idx(input int base, input int beat, input logic [1:0] burst);
        return (burst == 2'b00) ? base : (base + beat) % DEPTH;
    endfunction

    task automatic aw_send(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
        int budget = 0;
        axi_awvalid_i = 1'b1; axi_awaddr_i = addr; axi_awid_i = id;
        axi_awlen_i = len; axi_awburst_i = burst;
        while (axi_awready_o !== 1'b1 && budget < 50) begin tick(); budget++; end
        check("aw_handshake", 64'(budget < 50), 64'(1));
        tick();
        axi_awvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input int idx);
        int budget = 0;
        axi_wvalid_i = 1'b1; axi_wdata_i = data; axi_wstrb_i = strb; axi_wlast_i = last;
        while (axi_wready_o !== 1'b1 && budget < 50) begin tick(); budget++; end
        check("w_handshake", 64'(budget < 50), 64'(1));
        tick();
        for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
    endtask

    // Sends nbeats beats from wd_q/ws_q; wlast marks the final one even if nbeats != len+1.
    task automatic do_write(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input int bdelay);
        int          budget = 0;
        logic [1:0]  exp_resp;
        aw_send(addr, id, len, burst);
        for (int b = 0; b < nbeats; b++)
            w_beat(wd_q[b], ws_q[b], b == nbeats - 1, beat_idx(word_of(addr), b, burst));
        check("w_ready_drop", 64'(axi_wready_o), 64'(0));
        exp_resp = (nbeats == int'(len) + 1 && !burst[1]) ? 2'b00 : 2'b10;
        while (axi_bvalid_o !== 1'b1 && budget < 50) begin tick(); budget++; end
        check("b_valid", 64'({axi_bvalid_o, axi_bid_o, axi_bresp_o}), 64'({1'b1, id, exp_resp}));
        for (int d = 0; d < bdelay; d++) begin
            tick();
            check("b_hold", 64'({axi_bvalid_o, axi_bid_o, axi_bresp_o}), 64'({1'b1, id, exp_resp}));
        end
        axi_bready_i = 1'b1;
        tick();
        axi_bready_i = 1'b0;
        check("b_done", 64'(axi_bvalid_o), 64'(0));
    endtask

    task automatic ar_send(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
        int budget = 0;
        axi_arvalid_i = 1'b1; axi_araddr_i = addr; axi_arid_i = id;
        axi_arlen_i = len; axi_arburst_i = burst;
        while (axi_arready_o !== 1'b1 && budget < 50) begin tick(); budget++; end
        check("ar_handshake", 64'(budget < 50), 64'(1));
        tick();
        axi_arvalid_i = 1'b0;
    endtask

    // mode 0: rready held high; 1: rready pattern 1,0,0,1 repeating; 2: random rready.
    task automatic do_read(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int mode);
        int          b = 0;
        int          cyc = 0;
        int          idx;
        logic        rr;
        logic        took;
        logic [1:0]  exp_resp;
        exp_resp = burst[1] ? 2'b10 : 2'b00;
        ar_send(addr, id, len, burst);
        check("r_latency_n1", 64'(axi_rvalid_o), 64'(0));
        tick();
        check("r_latency_n2", 64'(axi_rvalid_o), 64'(1));
        while (b <= int'(len) && cyc < 2000) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            axi_rready_i = rr;
            took = 1'b0;
            if (axi_rvalid_o === 1'b1) begin
                idx = beat_idx(word_of(addr), b, burst);
                check("r_beat", 64'({axi_rid_o, axi_rresp_o, axi_rlast_o, axi_rdata_o}),
                      64'({id, exp_resp, b == int'(len), model[idx]}));
                took = rr;
            end
            tick();
            if (took) b++;
            cyc++;
        end
        axi_rready_i = 1'b0;
        check("r_beat_count", 64'(b), 64'(int'(len) + 1));
        check("r_idle", 64'({axi_rvalid_o, axi_arready_o}), 64'({1'b0, 1'b1}));
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 64'({axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o}),
              64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          nb;

        // Reset values and registered ready rise.
        repeat (3) tick();
        check_quiet("reset_quiet");
        check("reset_resp_ids", 64'({axi_bresp_o, axi_bid_o, axi_rresp_o, axi_rid_o, axi_rlast_o}),
              64'(0));
        check("reset_rdata", 64'(axi_rdata_o), 64'(0));
        reset = 1'b0;
        check("ready_before_edge", 64'({axi_awready_o, axi_arready_o}), 64'(0));
        tick();
        check("ready_after_edge", 64'({axi_awready_o, axi_arready_o, axi_wready_o}), 64'(3'b110));

        // Fill the whole SRAM with four maximum-length INCR bursts.
        for (int q = 0; q < 4; q++) begin
            wd_q.delete(); ws_q.delete();
            for (int i = 0; i < 256; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hf); end
            do_write(27'(q * 1024), 4'(q), 8'd255, 2'b01, 256, 0);
        end

        // Basic store/fetch.
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA0 + 32'(i)); ws_q.push_back(4'hf); end
        do_write(27'd0, 4'd2, 8'd3, 2'b01, 4, 2);
        do_read(27'd0, 4'd4, 8'd3, 2'b01, 0);

        // Byte strobes merge into the existing word.
        wd_q = '{32'hFFFF_FFFF}; ws_q = '{4'hf};
        do_write(27'd16, 4'd1, 8'd0, 2'b01, 1, 0);
        wd_q = '{32'h1234_5678}; ws_q = '{4'b0101};
        do_write(27'd16, 4'd1, 8'd0, 2'b01, 1, 0);
        do_read(27'd16, 4'd1, 8'd0, 2'b01, 0);

        // Stalled read with rready pattern.
        do_read(27'd0, 4'd5, 8'd7, 2'b01, 1);

        // INCR wrap at the top of the SRAM, read back also through an aliased address.
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 4; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hf); end
        do_write(27'hFFC, 4'd6, 8'd3, 2'b01, 4, 0);
        do_read(27'hFFC, 4'd6, 8'd3, 2'b01, 0);
        do_read(27'h40_0FFC, 4'd7, 8'd3, 2'b01, 2);

        // Early and late wlast, WRAP/reserved bursts, FIXED bursts.
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 4; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hf); end
        do_write(27'd400, 4'd3, 8'd3, 2'b01, 2, 0);
        do_read(27'd400, 4'd3, 8'd3, 2'b01, 0);
        do_write(27'd1200, 4'd3, 8'd1, 2'b01, 3, 1);
        do_read(27'd1200, 4'd3, 8'd3, 2'b01, 2);
        do_write(27'd2000, 4'd7, 8'd3, 2'b10, 4, 0);
        do_read(27'd2000, 4'd8, 8'd3, 2'b10, 2);
        do_read(27'd2000, 4'd9, 8'd2, 2'b11, 0);
        do_write(27'd2400, 4'd9, 8'd3, 2'b00, 4, 0);
        do_read(27'd2400, 4'd9, 8'd2, 2'b00, 2);

        // Random bursts.
        for (int t = 0; t < 20; t++) begin
            addr  = 27'($urandom);
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 3));
            nb    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, int'(len) + 2) : int'(len) + 1;
            wd_q.delete(); ws_q.delete();
            for (int i = 0; i < nb; i++) begin
                wd_q.push_back($urandom); ws_q.push_back(4'($urandom_range(0, 15)));
            end
            do_write(addr, 4'($urandom_range(0, 15)), len, burst, nb, $urandom_range(0, 2));
            do_read(addr, 4'($urandom_range(0, 15)), len, 2'($urandom_range(0, 3)), 2);
        end

        // Reset during W_DATA: accepted beats stay written, no B afterwards.
        aw_send(27'd800, 4'd5, 8'd7, 2'b01);
        w_beat(32'hDEAD_0001, 4'hf, 1'b0, 200);
        w_beat(32'hDEAD_0002, 4'hf, 1'b0, 201);
        axi_wvalid_i = 1'b1; axi_wdata_i = 32'hBAD0_BAD0; axi_wstrb_i = 4'hf;
        reset = 1'b1;
        tick();
        axi_wvalid_i = 1'b0;
        check_quiet("reset_mid_write");
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("no_b_after_reset", 64'({axi_bvalid_o, axi_wready_o}), 64'(0));
            tick();
        end

        // Reset during R_DATA: no further R beats.
        ar_send(27'd800, 4'd6, 8'd7, 2'b01);
        tick();
        reset = 1'b1;
        tick();
        check_quiet("reset_mid_read");
        check("reset_mid_read_r", 64'({axi_rlast_o, axi_rresp_o, axi_rid_o, axi_rdata_o}), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_r_after_reset", 64'(axi_rvalid_o), 64'(0));
        end
        do_read(27'd800, 4'd2, 8'd2, 2'b01, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 (subset) responder backed by on-chip single-clock SRAM, presenting the same AXI port set as the DDR3 controller's AXI slave port.
- Used as a drop-in memory target for the system-level AXI initiators and the bench store/fetch tasks when DDR3 is absent.
- Also serves as a golden reference for the controller's AXI behaviour.
- Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.

Parameters:
- WIDTH, 32, data width in bits (multiple of 8)
- ADDRS, 27, AXI byte-address width
- REQID, 4, AXI ID width
- DEPTH_BITS, 10, log2 of SRAM depth in WIDTH-bit words

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- axi_awvalid_i  in  1  write-address valid
- axi_awready_o  out  1  write-address ready
- axi_awaddr_i  in  ADDRS  write byte address
- axi_awid_i  in  REQID  write ID
- axi_awlen_i  in  8  beats minus one
- axi_awburst_i  in  2  burst type
- axi_wvalid_i  in  1  write-data valid
- axi_wready_o  out  1  write-data ready
- axi_wlast_i  in  1  final write beat
- axi_wstrb_i  in  WIDTH/8  byte strobes
- axi_wdata_i  in  WIDTH  write data
- axi_bvalid_o  out  1  write response valid
- axi_bready_i  in  1  write response ready
- axi_bresp_o  out  2  write response
- axi_bid_o  out  REQID  write response ID
- axi_arvalid_i  in  1  read-address valid
- axi_arready_o  out  1  read-address ready
- axi_araddr_i  in  ADDRS  read byte address
- axi_arid_i  in  REQID  read ID
- axi_arlen_i  in  8  beats minus one
- axi_arburst_i  in  2  burst type
- axi_rvalid_o  out  1  read data valid
- axi_rready_i  in  1  read data ready
- axi_rlast_o  out  1  final read beat
- axi_rresp_o  out  2  read response
- axi_rid_o  out  REQID  read ID
- axi_rdata_o  out  WIDTH  read data

Behaviour:

Reset (clock and reset as already decided):
- All valid/ready outputs 0; bresp/rresp 00; bid/rid 0; rdata 0; rlast 0.
- Both FSMs return to IDLE. SRAM contents are preserved.
- Reset mid-burst abandons the burst; no B or R is issued for it.
- Ready outputs are registered: awready/arready rise on the first clock edge after reset deasserts.

Addressing and bursts:
- Word index = addr[log2(WIDTH/8)+DEPTH_BITS-1 : log2(WIDTH/8)]; upper address bits are ignored (aliasing).
- INCR (01): index+1 per beat, wrapping modulo 2^DEPTH_BITS.
- FIXED (00): index held for the whole burst.
- WRAP (10) and reserved (11): treated as INCR; response is forced to SLVERR (10).

Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: awready=1. On AW handshake, capture id, index, len and burst; register the error flag; go to W_DATA with awready=0, wready=1.
- W_DATA: each W handshake writes wdata into SRAM bytes where wstrb=1, then advances index and beat count.
- On the handshake with wlast=1: wready=0, go to W_RESP.
  - bresp=00 if beat count == len+1 and burst ok, else 10.
  - Early or late wlast gives SLVERR, but every accepted beat is still written.
- W_RESP: bvalid=1 with bid = captured id; hold until bready. Then bvalid=0, W_IDLE, awready=1 the next cycle.
- Minimum AW-to-AW spacing is len+3 cycles.

Read FSM (R_IDLE -> R_FETCH -> R_DATA -> R_IDLE):
- R_IDLE: arready=1. On AR handshake, capture fields; go to R_FETCH with the SRAM read issued.
- R_FETCH: one cycle for the synchronous SRAM read.
- R_DATA: rvalid=1 starting cycle N+2, where N is the AR handshake cycle.
  - rid = captured id; rresp = 00, or 10 for a bad burst on every beat; rlast=1 on beat len.
- Back-to-back beats when rready=1, via prefetch of the next index.
- When rvalid=1 and rready=0, rdata/rlast/rresp are held stable, using a one-entry skid register as needed.
- After the rlast handshake: rvalid=0, R_IDLE, arready=1 the next cycle.

SRAM and channel independence:
- SRAM has one write port and one read port, read-before-write: a same-cycle read and write to the same index returns the old data.
- Read and write engines run concurrently with no ordering between them.
- W beats presented before the AW handshake are not accepted (wready=0 in W_IDLE).

Test Plan:
- Store 4 beats at addr 0, len=3, INCR, id=2, wstrb=f, data A0..A3 -> one bvalid, bid=2, bresp=00; then read addr 0 len=3 id=4 -> rdata A0..A3, rid=4, rresp=00, rlast only on beat 4, first rvalid 2 cycles after AR handshake.
- Read addr 0 len=7 with rready toggling 1,0,0,1,... -> every beat delivered exactly once, in order; rdata stable while stalled; rlast on beat 8.
- Write 0xFFFFFFFF to addr 16, then 0x12345678 with wstrb=0101 -> read back 0xFF34FF78.
- INCR write len=3 starting at the last word index (2^DEPTH_BITS-1) -> beats land at indices 1023, 0, 1, 2; readback confirms.
- AW len=3 with wlast on beat 2 -> bresp=10, beats 1-2 written; AW with burst=10 -> bresp=10.
- Assert reset during W_DATA and R_DATA -> all valids/readies 0 next cycle; no B/R after reset; previously written data still readable.
